// File: rtl/mul_top.sv
// mul_top: sequential 4-bit shift-add multiply-accumulate, p = q*y + r.
// Inverse companion of the divider top level: accepts a quotient/divisor/
// remainder triple and rebuilds the dividend, using the same go/done/error
// handshake and exposing the FSM state code on CS.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   go    - start request, only honoured in IDLE
//   q     - quotient operand (multiplier)
//   y     - divisor operand (multiplicand)
//   r     - remainder operand (addend)
//   p     - result register, q*y + r after DONE, 0 after ERR
//   CS    - current FSM state code
//   error - one-cycle pulse while in ERR (r >= y or y == 0)
//   done  - one-cycle pulse while in DONE
module mul_top (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [3:0] q,
    input  logic [3:0] y,
    input  logic [3:0] r,
    output logic [7:0] p,
    output logic [3:0] CS,
    output logic       error,
    output logic       done
);

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_LOAD  = 4'd1;
    localparam logic [3:0] ST_CHECK = 4'd2;
    localparam logic [3:0] ST_ADD   = 4'd3;
    localparam logic [3:0] ST_SHIFT = 4'd4;
    localparam logic [3:0] ST_DONE  = 4'd5;
    localparam logic [3:0] ST_ERR   = 4'd6;

    logic [3:0] state_q, state_d;
    logic [7:0] acc_q,   acc_d;
    logic [7:0] m_q,     m_d;
    logic [3:0] mq_q,    mq_d;
    logic [2:0] cnt_q,   cnt_d;
    logic [7:0] pr_q,    pr_d;
    logic       done_q,  done_d;
    logic       error_q, error_d;

    // Next-state and datapath update for the shift-add sequence.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        m_d     = m_q;
        mq_d    = mq_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    // Operands are captured on the go edge; they are
                    // don't-care for the rest of the run.
                    state_d = ST_LOAD;
                    acc_d   = {4'b0000, r};
                    m_d     = {4'b0000, y};
                    mq_d    = q;
                    cnt_d   = 3'd4;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_CHECK;
                pr_d    = 8'h00;
            end
            ST_CHECK: begin
                // acc still holds r here, so acc >= m means r >= y:
                // not a remainder the divider could have produced.
                if ((m_q == 8'h00) || (acc_q >= m_q)) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                if (mq_q[0]) begin
                    acc_d = acc_q + m_q;
                end else begin
                    acc_d = acc_q;
                end
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                m_d   = {m_q[6:0], 1'b0};
                mq_d  = {1'b0, mq_q[3:1]};
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ADD;
                end
            end
            ST_DONE: begin
                pr_d    = acc_q;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                pr_d    = 8'h00;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up
    // exactly with CS showing DONE or ERR.
    always_comb begin
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERR);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= 8'h00;
            m_q     <= 8'h00;
            mq_q    <= 4'h0;
            cnt_q   <= 3'd0;
            pr_q    <= 8'h00;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            mq_q    <= mq_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign p     = pr_q;
    assign CS    = state_q;
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_mul_top.sv
`timescale 1ns/1ps
module tb_mul_top;

    logic       clk;
    logic       rst;
    logic       go;
    logic [3:0] q;
    logic [3:0] y;
    logic [3:0] r;
    logic [7:0] p;
    logic [3:0] CS;
    logic       error;
    logic       done;

    int checks;
    int failures;

    // Scoreboard entry: {expect_error, expected_p}
    logic [8:0] sb_q[$];
    logic       pend;
    logic [7:0] pend_p;

    mul_top dut (
        .clk   (clk),
        .rst   (rst),
        .go    (go),
        .q     (q),
        .y     (y),
        .r     (r),
        .p     (p),
        .CS    (CS),
        .error (error),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pop an expectation whenever done/error shows, then check p
    // one cycle later, once the result register has been written.
    always @(negedge clk) begin
        logic [8:0] e;
        if (pend) begin
            checks++;
            if (p !== pend_p) begin
                failures++;
                $display("FAIL result_p: got %0d expected %0d", p, pend_p);
            end
            pend = 1'b0;
        end
        if (done || error) begin
            checks++;
            if (done && error) begin
                failures++;
                $display("FAIL done_and_error: got done=%0b error=%0b expected exclusive", done, error);
            end
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: got done=%0b error=%0b expected none", done, error);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (error !== e[8] || done !== !e[8]) begin
                    failures++;
                    $display("FAIL outcome_kind: got done=%0b error=%0b expected error=%0b", done, error, e[8]);
                end
                pend_p = e[7:0];
                pend   = 1'b1;
            end
        end
    end

    function automatic logic [3:0] exp_cs(input int i, input logic is_err);
        if (is_err) begin
            case (i)
                0: return 4'd1;
                1: return 4'd2;
                2: return 4'd6;
                default: return 4'd0;
            endcase
        end
        if (i == 0) return 4'd1;
        if (i == 1) return 4'd2;
        if (i == 10) return 4'd5;
        if (i >= 11) return 4'd0;
        return (i % 2 == 0) ? 4'd3 : 4'd4;
    endfunction

    // Issue one operation starting at a negedge with the DUT in IDLE and
    // follow the CS trace cycle by cycle. hold keeps go high afterwards;
    // scramble changes the operands right after capture.
    task automatic run(input logic [3:0] tq, input logic [3:0] ty, input logic [3:0] tr,
                       input logic [7:0] ep, input logic is_err,
                       input logic hold, input logic scramble);
        int len;
        len = is_err ? 4 : 12;
        q  = tq;
        y  = ty;
        r  = tr;
        go = 1'b1;
        sb_q.push_back({is_err, ep});
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) begin
                go = hold;
                if (scramble) begin
                    q = 4'hF;
                    y = 4'h1;
                    r = 4'hE;
                end
            end
            checks++;
            if (CS !== exp_cs(i, is_err)) begin
                failures++;
                $display("FAIL cs_trace[%0d]: got %0d expected %0d", i, CS, exp_cs(i, is_err));
            end
            if (i == 1) begin
                checks++;
                if (p !== 8'h00) begin
                    failures++;
                    $display("FAIL p_cleared_at_load: got %0d expected 0", p);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pend     = 1'b0;
        pend_p   = 8'h00;
        rst = 1'b1;
        go  = 1'b0;
        q   = 4'h0;
        y   = 4'h0;
        r   = 4'h0;
        #1;
        checks++;
        if (CS !== 4'd0 || p !== 8'h00 || done !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got CS=%0d p=%0d done=%0b error=%0b expected 0 0 0 0", CS, p, done, error);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run(4'd3,  4'd4,  4'd1,  8'd13,  1'b0, 1'b0, 1'b0);
        run(4'd15, 4'd15, 4'd14, 8'd239, 1'b0, 1'b0, 1'b0);
        run(4'd0,  4'd5,  4'd4,  8'd4,   1'b0, 1'b0, 1'b0);
        run(4'd7,  4'd0,  4'd0,  8'd0,   1'b1, 1'b0, 1'b0);
        run(4'd3,  4'd4,  4'd1,  8'd13,  1'b0, 1'b0, 1'b0);
        run(4'd2,  4'd9,  4'd9,  8'd0,   1'b1, 1'b0, 1'b0);
        run(4'd1,  4'd1,  4'd0,  8'd1,   1'b0, 1'b0, 1'b0);

        // go held high: back-to-back runs, operands scrambled mid-run
        run(4'd2, 4'd3, 4'd2, 8'd8, 1'b0, 1'b1, 1'b1);
        run(4'd2, 4'd3, 4'd2, 8'd8, 1'b0, 1'b1, 1'b1);
        run(4'd2, 4'd3, 4'd2, 8'd8, 1'b0, 1'b0, 1'b1);

        // Reset during SHIFT aborts with no done/error
        q  = 4'd5;
        y  = 4'd5;
        r  = 4'd0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (CS !== 4'd4) begin
            failures++;
            $display("FAIL pre_reset_shift: got %0d expected 4", CS);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (CS !== 4'd0 || p !== 8'h00 || done !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL async_abort: got CS=%0d p=%0d done=%0b error=%0b expected 0 0 0 0", CS, p, done, error);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(4'd5, 4'd5, 4'd0, 8'd25, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0 || pend) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before limit");
        $fatal(1, "timeout");
    end

endmodule
